// File: rtl/nn_pkg.sv
// Shared network constants and types used by second_stage and the M weight streamer.
package nn_pkg;

  localparam int DATA_W     = 16;
  localparam int GROUP_LEN  = 16;
  localparam int NUM_GROUPS = 64;
  localparam int MATRIX_LEN = GROUP_LEN * NUM_GROUPS;

  // Position flags that ride alongside a RAM read until the element is presented.
  typedef struct packed {
    logic last_m;
    logic last_matrix;
  } rd_tag_t;

endpackage

// File: rtl/m_weight_streamer_if.sv
// Request/response handshake between second_stage (master) and the weight supplier (slave).
interface m_weight_streamer_if #(
  parameter int DATA_W = nn_pkg::DATA_W
) ();

  logic              m_element_requested;
  logic              m_element_ready;
  logic [DATA_W-1:0] m_element;
  logic              last_m_element;
  logic              last_matrix_element;

  modport master (
    output m_element_requested,
    input  m_element_ready,
    input  m_element,
    input  last_m_element,
    input  last_matrix_element
  );

  modport slave (
    input  m_element_requested,
    output m_element_ready,
    output m_element,
    output last_m_element,
    output last_matrix_element
  );

endinterface

// File: rtl/m_weight_ram.sv
// Single-port weight RAM: synchronous read with one-cycle latency, write has priority.
module m_weight_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/m_weight_streamer.sv
// Supplier end of the m-element request interface: streams the M matrix row-major from RAM,
// one element per accepted request, with a fixed two-edge request-to-ready latency.
module m_weight_streamer #(
  parameter int DATA_W     = nn_pkg::DATA_W,
  parameter int GROUP_LEN  = nn_pkg::GROUP_LEN,
  parameter int NUM_GROUPS = nn_pkg::NUM_GROUPS,
  parameter int ADDR_W     = 10,
  parameter int PEND_W     = 4
) (
  input  logic                clock,
  input  logic                clear_n,
  input  logic                en,
  input  logic                load_en,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic [DATA_W-1:0]   load_data,
  m_weight_streamer_if.slave  m_if,
  output logic                busy,
  output logic                overflow
);

  import nn_pkg::*;

  localparam int MATRIX_LEN = GROUP_LEN * NUM_GROUPS;
  localparam int GRP_W      = (GROUP_LEN > 1) ? $clog2(GROUP_LEN) : 1;

  logic [PEND_W-1:0] pending_count;
  logic [ADDR_W-1:0] read_addr;
  logic [GRP_W-1:0]  elem_in_group;
  logic              in_flight;
  rd_tag_t           in_flight_tag;

  logic              req;
  logic              issue;
  logic              pend_full;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  assign req       = m_if.m_element_requested;
  assign pend_full = (pending_count == '1);
  // A request may issue in its arrival cycle; loading owns the RAM port and blocks issue.
  assign issue     = en & ~load_en & ((pending_count != '0) | req);
  assign ram_we    = load_en;
  assign ram_addr  = load_en ? load_addr : read_addr;
  assign busy      = (pending_count != '0) | in_flight;

  m_weight_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .re    (issue),
    .addr  (ram_addr),
    .wdata (load_data),
    .rdata (ram_rdata)
  );

  // Pending requests; a request arriving while full and not draining is dropped.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      pending_count <= '0;
      overflow      <= 1'b0;
    end else if (req && !issue) begin
      if (pend_full) begin
        overflow <= 1'b1;
      end else begin
        pending_count <= pending_count + 1'b1;
      end
    end else if (!req && issue) begin
      pending_count <= pending_count - 1'b1;
    end
  end

  // Address sequencing and read tagging.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      read_addr     <= '0;
      elem_in_group <= '0;
      in_flight     <= 1'b0;
      in_flight_tag <= '0;
    end else begin
      in_flight <= issue;
      if (issue) begin
        in_flight_tag.last_m      <= (elem_in_group == GRP_W'(GROUP_LEN - 1));
        in_flight_tag.last_matrix <= (read_addr == ADDR_W'(MATRIX_LEN - 1));
        if (elem_in_group == GRP_W'(GROUP_LEN - 1)) begin
          elem_in_group <= '0;
        end else begin
          elem_in_group <= elem_in_group + 1'b1;
        end
        if (read_addr == ADDR_W'(MATRIX_LEN - 1)) begin
          read_addr <= '0;
        end else begin
          read_addr <= read_addr + 1'b1;
        end
      end
    end
  end

  // Output stage; m_element holds its value between ready pulses.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      m_if.m_element_ready     <= 1'b0;
      m_if.m_element           <= '0;
      m_if.last_m_element      <= 1'b0;
      m_if.last_matrix_element <= 1'b0;
    end else begin
      m_if.m_element_ready <= in_flight;
      if (in_flight) begin
        m_if.m_element           <= ram_rdata;
        m_if.last_m_element      <= in_flight_tag.last_m;
        m_if.last_matrix_element <= in_flight_tag.last_matrix;
      end else begin
        m_if.last_m_element      <= 1'b0;
        m_if.last_matrix_element <= 1'b0;
      end
    end
  end

endmodule

// File: doc/m_weight_streamer.md
Name: m_weight_streamer

Overview:
- Supplier (responder) end of the m-element request interface. Serves the M weight matrix to second_stage one 16-bit element per request.
- Holds the matrix in an internal synchronous RAM, loaded over a simple write port.
- Streams elements row-major. Flags the last element of each group with last_m_element and the last element of the whole matrix with last_matrix_element.

Parameters:
- DATA_W, 16, element width (signed fixed point; passed through, no arithmetic).
- GROUP_LEN, 16, elements per group; last_m_element marks the final one.
- NUM_GROUPS, 64, groups per matrix (16 z elements x 4 caches).
- ADDR_W, 10, RAM address width. Must satisfy 2**ADDR_W >= GROUP_LEN*NUM_GROUPS.
- PEND_W, 4, width of the pending-request counter; maximum 2**PEND_W-1 outstanding.

Ports:
- clock  in  1  single clock, rising edge.
- clear_n  in  1  asynchronous active-low reset.
- en  in  1  global enable; when low, no reads are issued.
- load_en  in  1  write load_data into RAM at load_addr this cycle.
- load_addr  in  ADDR_W  load address.
- load_data  in  DATA_W  load data.
- m_element_requested  in  1  one-cycle pulse per element wanted; may be asserted every cycle.
- m_element_ready  out  1  one-cycle pulse; m_element is valid this cycle.
- m_element  out  DATA_W  weight element; holds its last value between pulses.
- last_m_element  out  1  high with m_element_ready on the last element of a group.
- last_matrix_element  out  1  high with m_element_ready on element GROUP_LEN*NUM_GROUPS-1.
- busy  out  1  pending_count != 0, or a read is in flight.
- overflow  out  1  sticky; a request was dropped because pending_count was full.

Behaviour:
- Reset (clear_n low, asynchronous):
  - All outputs go to 0.
  - pending_count, read_addr, elem_in_group and the in-flight flag go to 0.
  - RAM contents are not cleared.
  - Reset mid-stream discards all pending and in-flight reads; no ready pulse follows.
- Pending counter:
  - Each cycle, req = m_element_requested, issue = read issued this cycle.
  - Next value: pending_count + req - issue.
  - If pending_count = max and req=1 and issue=0, the request is dropped, overflow sets, and the count stays at max.
- Issue rule: issue = en & ~load_en & (pending_count != 0 | req). A request can therefore issue in the same cycle it arrives.
- Load priority:
  - load_en blocks issue for that cycle.
  - Requests are still counted while loading.
  - Loading during streaming is legal; the element returned is whatever the RAM holds at read time.
- Latency, with a request at rising edge t and no stall:
  - Edge t: RAM read registered at read_addr.
  - Edge t+1: m_element, m_element_ready, last_m_element and last_matrix_element registered.
  - Fixed 2-edge latency. Back-to-back requests give back-to-back ready pulses.
- Address sequencing on each issue:
  - read_addr increments; elem_in_group increments.
  - last flag = (elem_in_group == GROUP_LEN-1). It travels with the read through the pipeline.
  - elem_in_group wraps to 0 after GROUP_LEN-1.
  - read_addr wraps to 0 after GROUP_LEN*NUM_GROUPS-1.
  - The matrix restarts automatically; no explicit restart is required.
- en low:
  - Issue freezes; requests still accumulate.
  - A read already issued still completes and produces its ready pulse.
- Simultaneous req and issue: pending_count unchanged.
- m_element_ready is never high for two reads of the same issue. The count of ready pulses equals the count of accepted requests.

Decomposition:
- Shared package nn_pkg holds DATA_W=16, GROUP_LEN=16, NUM_GROUPS=64 and the derived MATRIX_LEN = GROUP_LEN*NUM_GROUPS. second_stage and this block use the same values.
- One sub-module, m_weight_ram:
  - Single port, synchronous read, 1-cycle latency.
  - Write when we=1, with write priority; no read in a write cycle.
  - Inferable as block RAM.
- Counters and pipeline live in the top.

Test Plan:
- Reset/idle: hold clear_n=0 with req pulsing -> all outputs 0, no ready. Release -> outputs stay 0 with no requests.
- Single request: load M[k]=k+0x100 for all k, pulse req at edge 10 -> ready at edge 12 only, m_element=0x0100, last_m_element=0.
- Burst and group boundary: 17 consecutive req cycles -> 17 consecutive ready pulses carrying 0x0100..0x0110. last_m_element high only on the 16th (0x010F).
- Matrix wrap: 1025 requests -> element 1023 has last_matrix_element=1 and last_m_element=1. Element 1024 returns 0x0100 with both flags 0.
- Stall/backlog: en=0 during 20 req pulses -> pending saturates at 15, overflow=1, busy=1. Raise en -> exactly 15 ready pulses in consecutive cycles, then busy=0.
- Load collision and async reset: load_en high in the same cycle as req -> issue slips one cycle and ready arrives at t+3. Drop clear_n with 5 pending -> outputs 0 immediately, no later ready pulses.
